// File: rtl/mem_ready_gate.sv
// Memory-channel release gate: holds AXI_CLK_STABLE low until every enabled
// channel reports controller ready and PLL lock together for a qualification
// window. Adds a bring-up timeout with fault capture, plus an optional re-lock mode.

// Per-channel synchroniser for one asynchronous level input.
module mem_ready_gate_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the flop chain; reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

module mem_ready_gate #(
  parameter int NUM_CH         = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int RELOCK_MODE    = 0
) (
  input  logic              SYSCLK,
  input  logic              SYSRESET,
  input  logic [NUM_CH-1:0] CTRLR_READY,
  input  logic [NUM_CH-1:0] PLL_LOCK,
  input  logic [NUM_CH-1:0] CH_MASK,
  output logic              AXI_CLK_STABLE,
  output logic [NUM_CH-1:0] READY_STATUS,
  output logic              LOSS,
  output logic              TIMEOUT,
  output logic [NUM_CH-1:0] ERR_CH,
  output logic [2:0]        STATE
);
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_STABLE   = 3'd2,
    ST_RELEASED = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  // A zero timeout still needs a 1-bit counter so the declarations stay legal.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES);
  // The fault fires on the edge where the counter would reach TIMEOUT_CYCLES.
  localparam logic [TW-1:0] TMO_LAST  = TMO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

  logic [NUM_CH-1:0] rdy_s, lck_s, qual;
  logic              all_ok;

  state_e            state_q, state_d;
  logic [SW-1:0]     stab_q, stab_d;
  logic [TW-1:0]     tmo_q, tmo_d, tmo_inc;
  logic              tmo_hit;
  logic              axi_q, axi_d;
  logic              loss_q, loss_d;
  logic              tout_q, tout_d;
  logic [NUM_CH-1:0] err_q, err_d;

  // One pair of synchronisers per channel; a channel qualifies only when both agree.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    mem_ready_gate_sync #(.STAGES(SYNC_STAGES)) u_rdy (
      .clk_i(SYSCLK), .rst_i(SYSRESET), .d_i(CTRLR_READY[ch]), .q_o(rdy_s[ch])
    );
    mem_ready_gate_sync #(.STAGES(SYNC_STAGES)) u_lck (
      .clk_i(SYSCLK), .rst_i(SYSRESET), .d_i(PLL_LOCK[ch]), .q_o(lck_s[ch])
    );
  end

  assign qual    = rdy_s & lck_s;
  assign all_ok  = &(qual | CH_MASK);
  assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);
  assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

  // Next-state, counters and sticky status; timeout outranks release.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    loss_d  = loss_q;
    tout_d  = tout_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT;
        stab_d  = '0;
        tmo_d   = '0;
      end
      ST_WAIT: begin
        if (TMO_EN) tmo_d = tmo_inc;
        if (tmo_hit) begin
          state_d = ST_FAULT;
          tout_d  = 1'b1;
          err_d   = ~qual & ~CH_MASK;
        end else if (all_ok) begin
          state_d = ST_STABLE;
          stab_d  = SW'(1);
        end
      end
      ST_STABLE: begin
        if (TMO_EN) tmo_d = tmo_inc;
        if (tmo_hit) begin
          state_d = ST_FAULT;
          tout_d  = 1'b1;
          err_d   = ~qual & ~CH_MASK;
        end else if (!all_ok) begin
          state_d = ST_WAIT;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_RELEASED;
        end else begin
          stab_d  = stab_q + SW'(1);
        end
      end
      ST_RELEASED: begin
        if (!all_ok) begin
          loss_d = 1'b1;
          if (RELOCK_MODE != 0) begin
            state_d = ST_WAIT;
            stab_d  = '0;
            tmo_d   = '0;
          end
        end
      end
      ST_FAULT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // Release is a flop of its own so the bridge never sees state-decode glitches.
  assign axi_d = (state_d == ST_RELEASED);

  // State and status registers with synchronous reset.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state_q <= ST_IDLE;
      stab_q  <= '0;
      tmo_q   <= '0;
      axi_q   <= 1'b0;
      loss_q  <= 1'b0;
      tout_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      tmo_q   <= tmo_d;
      axi_q   <= axi_d;
      loss_q  <= loss_d;
      tout_q  <= tout_d;
      err_q   <= err_d;
    end
  end

  assign AXI_CLK_STABLE = axi_q;
  assign READY_STATUS   = qual;
  assign LOSS           = loss_q;
  assign TIMEOUT        = tout_q;
  assign ERR_CH         = err_q;
  assign STATE          = state_q;
endmodule

// File: tb/tb_mem_ready_gate.sv
// Directed bench for mem_ready_gate: three instances share stimulus
// (a: defaults, b: TIMEOUT_CYCLES=100, c: RELOCK_MODE=1).
module tb_mem_ready_gate;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rdy, lck, msk;

  logic       axi_a, loss_a, tout_a, axi_b, loss_b, tout_b, axi_c, loss_c, tout_c;
  logic [1:0] rs_a, err_a, rs_b, err_b, rs_c, err_c;
  logic [2:0] st_a, st_b, st_c;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mem_ready_gate u_a (
    .SYSCLK(clk), .SYSRESET(rst), .CTRLR_READY(rdy), .PLL_LOCK(lck), .CH_MASK(msk),
    .AXI_CLK_STABLE(axi_a), .READY_STATUS(rs_a), .LOSS(loss_a), .TIMEOUT(tout_a),
    .ERR_CH(err_a), .STATE(st_a)
  );
  mem_ready_gate #(.TIMEOUT_CYCLES(100)) u_b (
    .SYSCLK(clk), .SYSRESET(rst), .CTRLR_READY(rdy), .PLL_LOCK(lck), .CH_MASK(msk),
    .AXI_CLK_STABLE(axi_b), .READY_STATUS(rs_b), .LOSS(loss_b), .TIMEOUT(tout_b),
    .ERR_CH(err_b), .STATE(st_b)
  );
  mem_ready_gate #(.RELOCK_MODE(1)) u_c (
    .SYSCLK(clk), .SYSRESET(rst), .CTRLR_READY(rdy), .PLL_LOCK(lck), .CH_MASK(msk),
    .AXI_CLK_STABLE(axi_c), .READY_STATUS(rs_c), .LOSS(loss_c), .TIMEOUT(tout_c),
    .ERR_CH(err_c), .STATE(st_c)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Two reset edges; edge 1 afterwards is the IDLE->WAIT edge.
  task automatic do_reset(input logic [1:0] r, input logic [1:0] l, input logic [1:0] m);
    rst = 1'b1; rdy = r; lck = l; msk = m;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: staggered arrival, ch1 sampled high at edge 40 -> release at 58
    do_reset(2'b00, 2'b11, 2'b00);
    chk("rst_axi",   32'(axi_a),  0);
    chk("rst_loss",  32'(loss_a), 0);
    chk("rst_tout",  32'(tout_a), 0);
    chk("rst_err",   32'(err_a),  0);
    chk("rst_rs",    32'(rs_a),   0);
    chk("rst_state", 32'(st_a),   0);
    run_to(1);
    chk("t1_wait", 32'(st_a), 1);
    run_to(9);  rdy[0] = 1'b1;
    run_to(39); rdy[1] = 1'b1;
    run_to(40); chk("t1_rs40", 32'(rs_a), 1);
    run_to(41); chk("t1_rs41", 32'(rs_a), 3);
    run_to(57); chk("t1_axi57", 32'(axi_a), 0);
    chk("t1_st57", 32'(st_a), 2);
    run_to(58); chk("t1_axi58", 32'(axi_a), 1);
    chk("t1_st58",   32'(st_a),   3);
    chk("t1_loss",   32'(loss_a), 0);
    chk("t1_tout",   32'(tout_a), 0);

    // Test 2: ch1 drop for edges 8..10 restarts qualification, release at 29
    do_reset(2'b11, 2'b11, 2'b00);
    run_to(7);  rdy[1] = 1'b0;
    run_to(9);  chk("t2_st9",  32'(st_a), 2);
    run_to(10); chk("t2_st10", 32'(st_a), 1);
    rdy[1] = 1'b1;
    run_to(28); chk("t2_axi28", 32'(axi_a), 0);
    chk("t2_st28", 32'(st_a), 2);
    run_to(29); chk("t2_axi29", 32'(axi_a), 1);

    // Test 3: timeout on instance b with only ch0 ready
    do_reset(2'b01, 2'b11, 2'b00);
    run_to(100); chk("t3_st100",   32'(st_b),   1);
    chk("t3_tout100", 32'(tout_b), 0);
    run_to(101); chk("t3_tout101", 32'(tout_b), 1);
    chk("t3_err",  32'(err_b), 2);
    chk("t3_st",   32'(st_b),  4);
    chk("t3_axi",  32'(axi_b), 0);
    rdy = 2'b11;
    run_to(140); chk("t3_st_hold",   32'(st_b),   4);
    chk("t3_err_hold",  32'(err_b),  2);
    chk("t3_tout_hold", 32'(tout_b), 1);
    chk("t3_axi_hold",  32'(axi_b),  0);
    do_reset(2'b00, 2'b00, 2'b00);
    chk("t3_rst_tout", 32'(tout_b), 0);
    chk("t3_rst_err",  32'(err_b),  0);
    chk("t3_rst_st",   32'(st_b),   0);

    // Tests 4/5: PLL_LOCK[0] drop after release, c re-locks, a stays released
    do_reset(2'b11, 2'b11, 2'b00);
    run_to(18); chk("t4_axi18", 32'(axi_c), 0);
    run_to(19); chk("t4_axi19", 32'(axi_c), 1);
    chk("t5_axi19", 32'(axi_a), 1);
    run_to(25); lck[0] = 1'b0;
    run_to(27); chk("t4_axi27",  32'(axi_c),  1);
    chk("t4_loss27", 32'(loss_c), 0);
    run_to(28); chk("t4_axi28",  32'(axi_c),  0);
    chk("t4_loss28", 32'(loss_c), 1);
    chk("t4_st28",   32'(st_c),   1);
    chk("t5_axi28",  32'(axi_a),  1);
    chk("t5_loss28", 32'(loss_a), 1);
    chk("t5_st28",   32'(st_a),   3);
    run_to(29); lck[0] = 1'b1;
    run_to(47); chk("t4_axi47", 32'(axi_c), 0);
    run_to(48); chk("t4_axi48",  32'(axi_c),  1);
    chk("t4_loss48", 32'(loss_c), 1);
    chk("t5_axi48",  32'(axi_a),  1);

    // Test 6: ch1 masked, ch0 sampled high at edge 5 -> release at 23
    do_reset(2'b00, 2'b00, 2'b10);
    run_to(4); rdy = 2'b01; lck = 2'b01;
    run_to(22); chk("t6_axi22", 32'(axi_a), 0);
    chk("t6_st22", 32'(st_a), 2);
    run_to(23); chk("t6_axi23", 32'(axi_a), 1);
    // Reset in the middle of STABLE
    do_reset(2'b00, 2'b00, 2'b10);
    run_to(4); rdy = 2'b01; lck = 2'b01;
    run_to(11); chk("t6_st11", 32'(st_a), 2);
    rst = 1'b1;
    tick();
    chk("t6_rst_st",   32'(st_a),   0);
    chk("t6_rst_axi",  32'(axi_a),  0);
    chk("t6_rst_rs",   32'(rs_a),   0);
    chk("t6_rst_loss", 32'(loss_a), 0);
    chk("t6_rst_err",  32'(err_a),  0);
    rst = 1'b0;

    // All channels masked: release STABLE_CYCLES+1 edges after leaving IDLE
    do_reset(2'b00, 2'b00, 2'b11);
    run_to(17); chk("tm_axi17", 32'(axi_a), 0);
    run_to(18); chk("tm_axi18", 32'(axi_a), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_ready_gate.md
Name: mem_ready_gate

Overview:
- Synthesizable release gate that holds the PCIe AXI bridge's AXI_CLK_STABLE low until every enabled memory channel is ready: controller ready and PLL locked.
- Generalises the DDR3/DDR4 bring-up ordering to NUM_CH channels.
- Adds input synchronisation, a stability qualification window, a bring-up timeout with per-channel fault capture, and an optional re-lock mode.
- Sits in the top-level between the DDR controllers and PCIe_EP.

Parameters:
NUM_CH, 2, number of memory channels monitored (1..16)
SYNC_STAGES, 2, synchroniser flops per ready/lock input (2..4)
STABLE_CYCLES, 16, consecutive cycles all enabled channels must stay qualified before release (>=1)
TIMEOUT_CYCLES, 1048576, bring-up timeout in cycles; 0 disables timeout
RELOCK_MODE, 0, 0 = release is sticky; 1 = loss of qualification drops release and re-qualifies

Ports:
SYSCLK  input  1  system clock
SYSRESET  input  1  synchronous active-high reset
CTRLR_READY  input  NUM_CH  per-channel controller ready, asynchronous to SYSCLK
PLL_LOCK  input  NUM_CH  per-channel PLL lock, asynchronous to SYSCLK
CH_MASK  input  NUM_CH  1 = channel ignored; quasi-static, change only during reset
AXI_CLK_STABLE  output  1  release to PCIe AXI bridge
READY_STATUS  output  NUM_CH  synchronised CTRLR_READY & PLL_LOCK per channel
LOSS  output  1  sticky: an enabled channel lost qualification after release
TIMEOUT  output  1  sticky: bring-up timeout reached
ERR_CH  output  NUM_CH  unmasked, unqualified channels captured at timeout
STATE  output  3  FSM state encoding, for debug

Behaviour:
- Reset (SYSRESET=1 at a SYSCLK edge):
  - Outputs: AXI_CLK_STABLE=0, LOSS=0, TIMEOUT=0, ERR_CH=0, READY_STATUS=0, STATE=IDLE(0).
  - Synchronisers cleared.
  - Reset mid-operation aborts any state, including FAULT.
- Qualification:
  - q[i] = sync(CTRLR_READY[i]) & sync(PLL_LOCK[i]) through SYNC_STAGES flops; READY_STATUS=q.
  - all_ok = &(q | CH_MASK).
- States (encoding): IDLE=0, WAIT=1, STABLE=2, RELEASED=3, FAULT=4.
  - IDLE: one cycle after reset deasserts -> WAIT. Clear stability counter and timeout counter.
  - WAIT: all_ok -> STABLE, with stability counter cleared to 1.
  - STABLE: increment stability counter while all_ok.
    - !all_ok -> WAIT; stability counter cleared; timeout counter not cleared.
    - Counter == STABLE_CYCLES with all_ok -> RELEASED.
  - RELEASED: AXI_CLK_STABLE=1, registered, asserted on the edge entering RELEASED.
    - !all_ok sets LOSS=1.
    - RELOCK_MODE=1: also go to WAIT and deassert AXI_CLK_STABLE on the same edge; timeout counter restarts from 0.
    - RELOCK_MODE=0: stay in RELEASED with AXI_CLK_STABLE=1.
  - FAULT: TIMEOUT=1; ERR_CH = ~q & ~CH_MASK sampled on the entry edge, then held. AXI_CLK_STABLE=0. Exit only via reset.
- Timeout:
  - Counter increments every cycle in WAIT and STABLE and saturates.
  - Reaching TIMEOUT_CYCLES -> FAULT. This takes priority over a simultaneous STABLE->RELEASED transition.
  - TIMEOUT_CYCLES=0: counter inactive, FAULT unreachable.
- Latency:
  - Inputs stable high from sampling edge E: AXI_CLK_STABLE rises at edge E+SYNC_STAGES+STABLE_CYCLES (edge E+18 with defaults).
  - A glitch shorter than STABLE_CYCLES restarts qualification.
- All channels masked: all_ok=1, so release occurs STABLE_CYCLES+1 cycles after leaving IDLE.
- Counter widths: clog2(STABLE_CYCLES+1) and clog2(TIMEOUT_CYCLES+1). No wrap-around; both counters saturate.
- Channel arrival order is irrelevant; only simultaneous qualification counts.

Test Plan:
1. Defaults, CH_MASK=00; raise PLL_LOCK=11, then CTRLR_READY[0] at cycle 10 and CTRLR_READY[1] at cycle 40 -> AXI_CLK_STABLE=1 at cycle 58, LOSS=0, TIMEOUT=0.
2. Both channels ready; drop CTRLR_READY[1] for 3 cycles during the STABLE window -> FSM returns to WAIT, release delayed by a full 16-cycle re-qualification after recovery.
3. TIMEOUT_CYCLES=100; only channel 0 ready -> at cycle 101 after IDLE: TIMEOUT=1, ERR_CH=10, STATE=4, AXI_CLK_STABLE=0, held until SYSRESET.
4. RELOCK_MODE=1, released; drop PLL_LOCK[0] -> AXI_CLK_STABLE=0 at edge E+2, LOSS=1; restore -> re-release 18 cycles later, LOSS stays 1.
5. RELOCK_MODE=0, same drop -> AXI_CLK_STABLE stays 1, LOSS=1.
6. CH_MASK=10, channel 1 never ready -> release at E+18 from channel 0 alone. Assert SYSRESET mid-STABLE -> all outputs return to reset values on the next edge.
